// File: rtl/pipe_scheduler.sv
// Game-flow controller for the two pipe lanes: movement prescaler, lane spawn/stagger/recycle,
// gap-height LFSR, saturating score and IDLE/RUN/LOST play state. All outputs are registered.
module pipe_scheduler #(
  parameter int         TICK_DIV  = 500000,
  parameter int         SPAWN_X   = 1000,
  parameter int         SPACING   = 500,
  parameter int         BIRD_X    = 150,
  parameter int         HMIN      = 100,
  parameter int         IDLE_Y    = 75,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Collide,
  output logic [9:0] PipePosXA,
  output logic [9:0] PipePosYA,
  output logic [9:0] PipePosXB,
  output logic [9:0] PipePosYB,
  output logic       PipeActiveA,
  output logic       PipeActiveB,
  output logic [7:0] Score,
  output logic       Tick,
  output logic [1:0] GameState
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LOST = 2'b10
  } state_t;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
  } lane_t;

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0]      X_SPAWN    = 10'(SPAWN_X);
  localparam logic [9:0]      X_BIRD     = 10'(BIRD_X);
  localparam logic [9:0]      Y_IDLE     = 10'(IDLE_Y);
  localparam logic [9:0]      Y_MIN      = 10'(HMIN);
  // Lane B is armed when lane A lands on this column; a negative value means B never spawns.
  localparam int              TRIG       = SPAWN_X - SPACING;
  localparam bit              TRIG_OK    = (TRIG >= 0);
  localparam logic [9:0]      X_TRIG     = TRIG_OK ? 10'(TRIG) : 10'd0;
  localparam lane_t           LANE_IDLE  = '{active: 1'b0, x: 10'h3FF, y: Y_IDLE};

  state_t        state_q, state_d;
  lane_t         lane_a_q, lane_a_d, lane_b_q, lane_b_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    score_q, score_d;
  logic          tick_q, tick_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          start_q;
  logic          start_edge;
  logic [9:0]    h_a, h_b;
  logic          cross_a, cross_b;

  // Recycle at the left edge instead of decrementing, so X never wraps below zero.
  function automatic lane_t lane_step(input lane_t l, input logic [9:0] h);
    lane_t n;
    n = l;
    if (l.x == 10'd0) begin
      n.x = X_SPAWN;
      n.y = h;
    end else begin
      n.x = l.x - 10'd1;
    end
    return n;
  endfunction

  assign start_edge = Start & ~start_q;
  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign h_a        = Y_MIN + {3'b000, lfsr_q[6:0]};
  assign h_b        = Y_MIN + {3'b000, lfsr_q[7:1]};
  assign cross_a    = lane_a_q.active && (lane_a_q.x != 10'd0) && (lane_a_q.x == X_BIRD);
  assign cross_b    = lane_b_q.active && (lane_b_q.x != 10'd0) && (lane_b_q.x == X_BIRD);

  always_comb begin
    logic [1:0] gain;
    logic [8:0] score_sum;
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    state_d   = state_q;
    lane_a_d  = lane_a_q;
    lane_b_d  = lane_b_q;
    presc_d   = presc_q;
    score_d   = score_q;
    tick_d    = 1'b0;
    gain      = 2'b00;
    score_sum = 9'd0;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d  = RUN;
          score_d  = 8'd0;
          presc_d  = '0;
          lane_a_d = '{active: 1'b1, x: X_SPAWN, y: h_a};
        end
      end

      RUN: begin
        // Collision wins over a coincident tick: the frame freezes exactly as it was hit.
        if (Collide) begin
          state_d = LOST;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (lane_a_q.active) lane_a_d = lane_step(lane_a_q, h_a);
          if (lane_b_q.active) begin
            lane_b_d = lane_step(lane_b_q, h_b);
          end else if (TRIG_OK && lane_a_q.active && (lane_a_d.x == X_TRIG)) begin
            lane_b_d = '{active: 1'b1, x: X_SPAWN, y: h_b};
          end
          gain      = {1'b0, cross_a} + {1'b0, cross_b};
          score_sum = {1'b0, score_q} + {7'd0, gain};
          score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      LOST: begin
        if (start_edge) begin
          state_d  = IDLE;
          lane_a_d = LANE_IDLE;
          lane_b_d = LANE_IDLE;
          presc_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      lane_a_q <= LANE_IDLE;
      lane_b_q <= LANE_IDLE;
      presc_q  <= '0;
      score_q  <= 8'd0;
      tick_q   <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_a_q <= lane_a_d;
      lane_b_q <= lane_b_d;
      presc_q  <= presc_d;
      score_q  <= score_d;
      tick_q   <= tick_d;
      lfsr_q   <= lfsr_d;
      start_q  <= Start;
    end
  end

  assign PipePosXA   = lane_a_q.x;
  assign PipePosYA   = lane_a_q.y;
  assign PipeActiveA = lane_a_q.active;
  assign PipePosXB   = lane_b_q.x;
  assign PipePosYB   = lane_b_q.y;
  assign PipeActiveB = lane_b_q.active;
  assign Score       = score_q;
  assign Tick        = tick_q;
  assign GameState   = state_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Three differently parameterised schedulers driven with scheduled and random Start/Collide,
// each compared every cycle against a behavioural game model kept in the bench.
module tb_pipe_scheduler;

  localparam int N    = 3;
  localparam int NCYC = 12000;

  localparam int DIV0 = 4, SPX0 = 1000, SPC0 = 500, BRD0 = 150;
  localparam int DIV1 = 4, SPX1 = 160,  SPC1 = 500, BRD1 = 150;
  localparam int DIV2 = 2, SPX2 = 20,   SPC2 = 0,   BRD2 = 10;
  localparam logic [7:0] SEED0 = 8'hA5, SEED1 = 8'h3C, SEED2 = 8'hA5;

  logic       Clk;
  logic       Reset;
  logic       start   [N];
  logic       collide [N];
  logic [9:0] xa [N], ya [N], xb [N], yb [N];
  logic       act_a [N], act_b [N], tick [N];
  logic [7:0] score [N];
  logic [1:0] gs [N];

  int n_checks = 0;
  int n_errors = 0;

  // Model parameters and state, one slot per instance.
  int m_div[N], m_spawn[N], m_spacing[N], m_bird[N], m_seed[N];
  int m_st[N], m_xa[N], m_ya[N], m_xb[N], m_yb[N], m_aa[N], m_ab[N];
  int m_score[N], m_tick[N], m_presc[N], m_lfsr[N], m_sq[N];

  pipe_scheduler #(.TICK_DIV(DIV0), .SPAWN_X(SPX0), .SPACING(SPC0), .BIRD_X(BRD0),
                   .HMIN(100), .IDLE_Y(75), .LFSR_SEED(SEED0)) u0 (
    .Clk(Clk), .Reset(Reset), .Start(start[0]), .Collide(collide[0]),
    .PipePosXA(xa[0]), .PipePosYA(ya[0]), .PipePosXB(xb[0]), .PipePosYB(yb[0]),
    .PipeActiveA(act_a[0]), .PipeActiveB(act_b[0]), .Score(score[0]), .Tick(tick[0]),
    .GameState(gs[0]));

  pipe_scheduler #(.TICK_DIV(DIV1), .SPAWN_X(SPX1), .SPACING(SPC1), .BIRD_X(BRD1),
                   .HMIN(100), .IDLE_Y(75), .LFSR_SEED(SEED1)) u1 (
    .Clk(Clk), .Reset(Reset), .Start(start[1]), .Collide(collide[1]),
    .PipePosXA(xa[1]), .PipePosYA(ya[1]), .PipePosXB(xb[1]), .PipePosYB(yb[1]),
    .PipeActiveA(act_a[1]), .PipeActiveB(act_b[1]), .Score(score[1]), .Tick(tick[1]),
    .GameState(gs[1]));

  pipe_scheduler #(.TICK_DIV(DIV2), .SPAWN_X(SPX2), .SPACING(SPC2), .BIRD_X(BRD2),
                   .HMIN(100), .IDLE_Y(75), .LFSR_SEED(SEED2)) u2 (
    .Clk(Clk), .Reset(Reset), .Start(start[2]), .Collide(collide[2]),
    .PipePosXA(xa[2]), .PipePosYA(ya[2]), .PipePosXB(xb[2]), .PipePosYB(yb[2]),
    .PipeActiveA(act_a[2]), .PipeActiveB(act_b[2]), .Score(score[2]), .Tick(tick[2]),
    .GameState(gs[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_st[k] = 0;   m_xa[k] = 1023; m_xb[k] = 1023; m_ya[k] = 75; m_yb[k] = 75;
    m_aa[k] = 0;   m_ab[k] = 0;    m_score[k] = 0; m_tick[k] = 0; m_presc[k] = 0;
    m_lfsr[k] = m_seed[k]; m_sq[k] = 0;
  endtask

  // One clock of the game rules: st 0=IDLE 1=RUN 2=LOST.
  task automatic model_step(input int k, input int st_in, input int co);
    int edge_s, ha, hb, fb, gained, trig;
    edge_s = (st_in != 0) && (m_sq[k] == 0);
    ha     = 100 + (m_lfsr[k] % 128);
    hb     = 100 + (m_lfsr[k] / 2);
    fb     = ((m_lfsr[k] >> 7) ^ (m_lfsr[k] >> 5) ^ (m_lfsr[k] >> 4) ^ (m_lfsr[k] >> 3)) & 1;
    trig   = m_spawn[k] - m_spacing[k];
    m_tick[k] = 0;
    if (m_st[k] == 0) begin
      if (edge_s != 0) begin
        m_st[k] = 1; m_score[k] = 0; m_presc[k] = 0;
        m_aa[k] = 1; m_xa[k] = m_spawn[k]; m_ya[k] = ha;
      end
    end else if (m_st[k] == 1) begin
      if (co != 0) begin
        m_st[k] = 2;
      end else if (m_presc[k] == m_div[k] - 1) begin
        m_presc[k] = 0;
        m_tick[k]  = 1;
        gained     = 0;
        if (m_aa[k] != 0) begin
          if (m_xa[k] == 0) begin
            m_xa[k] = m_spawn[k]; m_ya[k] = ha;
          end else begin
            if (m_xa[k] == m_bird[k]) gained++;
            m_xa[k]--;
          end
        end
        if (m_ab[k] != 0) begin
          if (m_xb[k] == 0) begin
            m_xb[k] = m_spawn[k]; m_yb[k] = hb;
          end else begin
            if (m_xb[k] == m_bird[k]) gained++;
            m_xb[k]--;
          end
        end else if (trig >= 0 && m_aa[k] != 0 && m_xa[k] == trig) begin
          m_ab[k] = 1; m_xb[k] = m_spawn[k]; m_yb[k] = hb;
        end
        m_score[k] = (m_score[k] + gained > 255) ? 255 : m_score[k] + gained;
      end else begin
        m_presc[k]++;
      end
    end else begin
      if (edge_s != 0) begin
        m_st[k] = 0; m_presc[k] = 0;
        m_xa[k] = 1023; m_xb[k] = 1023; m_ya[k] = 75; m_yb[k] = 75; m_aa[k] = 0; m_ab[k] = 0;
      end
    end
    m_sq[k]   = st_in;
    m_lfsr[k] = ((m_lfsr[k] << 1) | fb) & 255;
  endtask

  task automatic compare_all(input int k);
    check($sformatf("u%0d.state", k), 32'(gs[k]),    m_st[k]);
    check($sformatf("u%0d.xa", k),    32'(xa[k]),    m_xa[k]);
    check($sformatf("u%0d.ya", k),    32'(ya[k]),    m_ya[k]);
    check($sformatf("u%0d.xb", k),    32'(xb[k]),    m_xb[k]);
    check($sformatf("u%0d.yb", k),    32'(yb[k]),    m_yb[k]);
    check($sformatf("u%0d.act_a", k), 32'(act_a[k]), m_aa[k]);
    check($sformatf("u%0d.act_b", k), 32'(act_b[k]), m_ab[k]);
    check($sformatf("u%0d.score", k), 32'(score[k]), m_score[k]);
    check($sformatf("u%0d.tick", k),  32'(tick[k]),  m_tick[k]);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, ".xa"},    32'(xa[0]),    1023);
    check({pfx, ".xb"},    32'(xb[0]),    1023);
    check({pfx, ".ya"},    32'(ya[0]),    75);
    check({pfx, ".yb"},    32'(yb[0]),    75);
    check({pfx, ".act_a"}, 32'(act_a[0]), 0);
    check({pfx, ".act_b"}, 32'(act_b[0]), 0);
    check({pfx, ".score"}, 32'(score[0]), 0);
    check({pfx, ".tick"},  32'(tick[0]),  0);
    check({pfx, ".state"}, 32'(gs[0]),    0);
  endtask

  initial begin
    int  col_cyc, col_xa, col_score, runs2;
    bit  col_armed_done, rst_low;
    logic [1:0] prev_gs2;

    m_div     = '{DIV0, DIV1, DIV2};
    m_spawn   = '{SPX0, SPX1, SPX2};
    m_spacing = '{SPC0, SPC1, SPC2};
    m_bird    = '{BRD0, BRD1, BRD2};
    m_seed    = '{int'(SEED0), int'(SEED1), int'(SEED2)};
    col_cyc = -1; col_xa = 0; col_score = 0; runs2 = 0; col_armed_done = 1'b0;
    prev_gs2 = 2'b00;

    Reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      start[k] = 1'b0; collide[k] = 1'b0; model_reset(k);
    end
    repeat (2) @(negedge Clk);
    check_reset_values("rst");
    Reset = 1'b1;
    for (int k = 0; k < N; k++) model_step(k, 0, 0);

    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      @(negedge Clk);
      for (int k = 0; k < N; k++) compare_all(k);

      // Asynchronous reset mid-RUN: outputs must clear before any clock edge.
      if (cyc == 2500) begin
        check("arst.pre_state", 32'(gs[0]), 1);
        #2 Reset = 1'b0;
        #1 check_reset_values("arst");
        for (int k = 0; k < N; k++) model_reset(k);
      end
      if (cyc == 2503) Reset = 1'b1;
      rst_low = (cyc >= 2500 && cyc < 2503);

      if (col_cyc >= 0 && cyc == col_cyc + 1) begin
        check("col.xa_frozen", 32'(xa[0]),   col_xa);
        check("col.state",     32'(gs[0]),   2);
        check("col.tick",      32'(tick[0]), 0);
      end
      if (col_cyc >= 0 && cyc == 4899) begin
        check("lost.xa_hold",    32'(xa[0]),    col_xa);
        check("lost.score_hold", 32'(score[0]), col_score);
      end
      if (cyc == 4901) begin
        check("restart.state", 32'(gs[0]),    0);
        check("restart.xa",    32'(xa[0]),    1023);
        check("restart.score", 32'(score[0]), col_score);
      end
      if (cyc > 2600 && cyc <= 10000 && prev_gs2 == 2'b00 && gs[2] == 2'b01) runs2++;
      prev_gs2 = gs[2];
      if (cyc == 9999)  check("u2.saturated", 32'(score[2]), 255);
      if (cyc == 10001) check("u2.run_entries", 32'(runs2), 1);
      if (cyc == 10500) check("u2.lost_no_edge", 32'(gs[2]), 2);

      // Instance 0: scripted run, collision on a tick, restart, then random play.
      collide[0] = 1'b0;
      if (cyc < 5000) begin
        start[0] = ((cyc >= 5 && cyc < 8) || (cyc >= 2520 && cyc < 2523) ||
                    (cyc >= 4900 && cyc < 4903)) ? 1'b1 : 1'b0;
        if (cyc >= 4700 && !col_armed_done && m_st[0] == 1 && m_presc[0] == m_div[0] - 1) begin
          collide[0]     = 1'b1;
          col_armed_done = 1'b1;
          col_cyc        = cyc;
          col_xa         = m_xa[0];
          col_score      = m_score[0];
        end
      end else begin
        if ($urandom_range(0, 39) == 0) start[0] = ~start[0];
        collide[0] = ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0;
      end

      // Instance 1: short lanes with a single pipe, random play throughout.
      if ($urandom_range(0, 29) == 0) start[1] = ~start[1];
      collide[1] = ($urandom_range(0, 799) == 0) ? 1'b1 : 1'b0;

      // Instance 2: lock-stepped lanes, Start held high through the whole run.
      if (cyc < 11000) begin
        start[2] = (cyc >= 2600) ? 1'b1 : 1'b0;
      end else if (cyc == 11000) begin
        start[2] = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        start[2] = ~start[2];
      end
      collide[2] = (cyc == 10000) ? 1'b1 : 1'b0;

      for (int k = 0; k < N; k++) begin
        if (rst_low) model_reset(k);
        else         model_step(k, int'(start[k]), int'(collide[k]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
